// File: rtl/pc_pkg.sv
// Shared fetch-stage definitions: redirect encodings and the default address width.
package pc_pkg;

    localparam int ASIZE_DEFAULT = 16;

    typedef enum logic [1:0] {
        REDIR_JUMP = 2'b00,
        REDIR_CALL = 2'b01,
        REDIR_RET  = 2'b10,
        REDIR_RSVD = 2'b11
    } redir_type_e;

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack: pushes wrap over the oldest entry, count saturates at RAS_DEPTH.
module pc_ras_stack #(
    parameter int ASIZE     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [ASIZE-1:0]           push_data_i,
    output logic [ASIZE-1:0]           top_data_o,
    output logic [$clog2(RAS_DEPTH):0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ASIZE-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, top_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic             full;

    // ptr_q is the next free slot; when full it points at the oldest entry, so a push overwrites it.
    assign top_ptr    = ptr_q - PW'(1);
    assign top_data_o = mem_q[top_ptr];
    assign count_o    = count_q;
    assign full       = (count_q == CW'(RAS_DEPTH));

    always_comb begin
        ptr_d       = ptr_q;
        count_d     = count_q;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        if (push_i) begin
            ptr_d = ptr_q + PW'(1);
            if (full) overflow_o = 1'b1;
            else      count_d    = count_q + CW'(1);
        end else if (pop_i) begin
            if (count_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                ptr_d   = top_ptr;
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer with step, stall and redirect sources.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               ASIZE      = ASIZE_DEFAULT,
    parameter logic [ASIZE-1:0] RESET_ADDR = '0,
    parameter int               STEP       = 1,
    parameter int               RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             redir_valid,
    input  logic [1:0]       redir_type,
    input  logic [ASIZE-1:0] redir_target,
    output logic [ASIZE-1:0] currPC,
    output logic             redir_taken,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam logic [ASIZE-1:0] STEP_V = ASIZE'(STEP);

    if (STEP < 1 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_params
        $error("pc_sequencer: STEP must be >= 1 and RAS_DEPTH a power of two >= 2");
    end

    logic [ASIZE-1:0] pc_q, pc_d, pc_seq;
    logic             taken_q;

    assign pc_seq      = pc_q + STEP_V;
    assign currPC      = pc_q;
    assign redir_taken = taken_q;

`ifdef PC_RAS_EN
    logic                       push, pop, overflow, underflow, err_q;
    logic [ASIZE-1:0]           top_data;
    logic [$clog2(RAS_DEPTH):0] count;

    pc_ras_stack #(
        .ASIZE     (ASIZE),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_seq),
        .top_data_o  (top_data),
        .count_o     (count),
        .overflow_o  (overflow),
        .underflow_o (underflow)
    );

    assign ras_empty = (count == '0);
    assign ras_full  = (count == ($clog2(RAS_DEPTH)+1)'(RAS_DEPTH));
    assign ras_err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | overflow | underflow;
    end
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

    // Redirect is a single-cycle request with no ready: redir_valid is sampled on every
    // edge and always honoured, even with en low (it doubles as a flush).
    always_comb begin
        pc_d = pc_q;
`ifdef PC_RAS_EN
        push = 1'b0;
        pop  = 1'b0;
`endif
        if (redir_valid) begin
            case (redir_type_e'(redir_type))
                REDIR_CALL: begin
`ifdef PC_RAS_EN
                    push = 1'b1;
`endif
                    pc_d = redir_target;
                end
                REDIR_RET: begin
`ifdef PC_RAS_EN
                    pop  = 1'b1;
                    pc_d = ras_empty ? redir_target : top_data;
`else
                    pc_d = redir_target;
`endif
                end
                default: pc_d = redir_target;
            endcase
        end else if (en) begin
            pc_d = pc_seq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_ADDR;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= redir_valid;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios pinned by literals, then random
// traffic compared every cycle against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int ASIZE     = 16;
    localparam int STEP      = 1;
    localparam int RAS_DEPTH = 4;
    localparam logic [1:0] T_JMP = 2'b00, T_CALL = 2'b01, T_RET = 2'b10, T_RSVD = 2'b11;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             redir_valid = 1'b0;
    logic [1:0]       redir_type = 2'b00;
    logic [ASIZE-1:0] redir_target = '0;
    logic [ASIZE-1:0] currPC;
    logic             redir_taken, ras_empty, ras_full, ras_err;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    // model state
    logic [ASIZE-1:0] m_pc;
    bit               m_taken, m_err;
    logic [ASIZE-1:0] m_ras[$];
    logic [ASIZE-1:0] exp_q[$];

    pc_sequencer #(
        .ASIZE      (ASIZE),
        .RESET_ADDR (16'h0000),
        .STEP       (STEP),
        .RAS_DEPTH  (RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .redir_valid  (redir_valid),
        .redir_type   (redir_type),
        .redir_target (redir_target),
        .currPC       (currPC),
        .redir_taken  (redir_taken),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_err      (ras_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: stack as a bounded queue, newest entry at the back
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc    = 16'h0000;
            m_taken = 1'b0;
            m_err   = 1'b0;
            m_ras.delete();
        end else begin
            m_taken = redir_valid;
            if (redir_valid) begin
                if (RAS_ON && redir_type == T_CALL) begin
                    if (m_ras.size() == RAS_DEPTH) begin
                        void'(m_ras.pop_front());
                        m_err = 1'b1;
                    end
                    m_ras.push_back(16'(m_pc + STEP));
                    m_pc = redir_target;
                end else if (RAS_ON && redir_type == T_RET) begin
                    if (m_ras.size() == 0) begin
                        m_pc  = redir_target;
                        m_err = 1'b1;
                    end else begin
                        m_pc = m_ras.pop_back();
                    end
                end else begin
                    m_pc = redir_target;
                end
            end else if (en) begin
                m_pc = 16'(m_pc + STEP);
            end
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            check("pc", currPC, m_pc);
            check("taken", redir_taken, m_taken);
            check("empty", ras_empty, m_ras.size() == 0);
            check("full", ras_full, m_ras.size() == RAS_DEPTH);
            check("err", ras_err, m_err);
        end
    end

    // driver: one cycle of stimulus, then settle just after the edge
    task automatic cyc(input bit e, input bit v, input logic [1:0] t, input logic [ASIZE-1:0] tgt);
        @(negedge clk);
        en = e; redir_valid = v; redir_type = t; redir_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [ASIZE-1:0] exp);
        check({name, "_dut"}, currPC, exp);
        check({name, "_model"}, m_pc, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; redir_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_pc", currPC, 16'h0000);
        check("rst_taken", redir_taken, 1'b0);
        check("rst_empty", ras_empty, 1'b1);
        check("rst_full", ras_full, 1'b0);
        check("rst_err", ras_err, 1'b0);
        cmp_on = 1'b1;

        // sequential step
        cyc(1, 0, T_JMP, 16'h0); pin("step1", 16'h0001);
        cyc(1, 0, T_JMP, 16'h0); pin("step2", 16'h0002);
        cyc(1, 0, T_JMP, 16'h0); pin("step3", 16'h0003);
        check("step_taken", redir_taken, 1'b0);

        // jump while stalled, then hold
        cyc(0, 1, T_JMP, 16'h0010);  pin("j10", 16'h0010);
        cyc(0, 1, T_JMP, 16'h0100);  pin("j100", 16'h0100);
        check("j_taken", redir_taken, 1'b1);
        cyc(0, 0, T_JMP, 16'hABCD);  pin("hold", 16'h0100);
        check("hold_taken", redir_taken, 1'b0);
        cyc(1, 1, T_RSVD, 16'h0123); pin("rsvd", 16'h0123);

        // call, two steps, return
        cyc(0, 1, T_JMP, 16'h0020);  pin("j20", 16'h0020);
        cyc(1, 1, T_CALL, 16'h0200); pin("call", 16'h0200);
        cyc(1, 0, T_JMP, 16'h0);     pin("c_s1", 16'h0201);
        cyc(1, 0, T_JMP, 16'h0);     pin("c_s2", 16'h0202);
        cyc(1, 1, T_RET, 16'h0999);  pin("ret", RAS_ON ? 16'h0021 : 16'h0999);
        check("ret_empty", ras_empty, 1'b1);

        // five calls overflow the stack; four returns give calls 5,4,3,2
        if (RAS_ON) begin
            cyc(0, 1, T_JMP, 16'h1000);
            for (int i = 1; i <= 5; i++) begin
                cyc(1, 1, T_CALL, 16'(16'h1000 + 16'h1000 * i));
                if (i == 4) begin
                    check("c4_full", ras_full, 1'b1);
                    check("c4_err", ras_err, 1'b0);
                end
            end
            check("c5_full", ras_full, 1'b1);
            check("c5_err", ras_err, 1'b1);
            exp_q = '{16'h5001, 16'h4001, 16'h3001, 16'h2001};
            while (exp_q.size() != 0) begin
                logic [ASIZE-1:0] e_addr;
                e_addr = exp_q.pop_front();
                cyc(1, 1, T_RET, 16'h0000);
                pin("ovf_ret", e_addr);
            end
            check("ovf_empty", ras_empty, 1'b1);
        end

        // return on empty stack falls back to the target
        do_reset();
        cyc(1, 1, T_RET, 16'h0300); pin("ret_empty", 16'h0300);
        check("ret_empty_err", ras_err, RAS_ON);

        // wrap, then call/return pair
        cyc(0, 1, T_JMP, 16'hFFFF);  pin("jffff", 16'hFFFF);
        cyc(1, 0, T_JMP, 16'h0);     pin("wrap", 16'h0000);
        check("wrap_taken", redir_taken, 1'b0);
        cyc(1, 1, T_CALL, 16'h0040); pin("call40", 16'h0040);
        cyc(1, 1, T_RET, 16'h0050);  pin("ret50", RAS_ON ? 16'h0001 : 16'h0050);
        check("ret50_err", ras_err, RAS_ON);

        // randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1 check("async_rst_pc", currPC, 16'h0000);
                check("async_rst_err", ras_err, 1'b0);
                @(posedge clk);
                #2 rst = 1'b0;
            end
            @(negedge clk);
            en           = ($urandom_range(0, 3) != 0);
            redir_valid  = ($urandom_range(0, 9) < 3);
            redir_type   = 2'($urandom_range(0, 3));
            redir_target = 16'($urandom_range(0, 16'hFFFF));
        end
        @(negedge clk);
        redir_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
